// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage bridge to a 64-bit byte-addressed data memory.
// Ports: req_* (valid/ready request in), resp_* (valid/ready response out),
//   mem_* (memory pins: address, writeData, MemWrite, MemRead, read_data),
//   busy (unit not idle). Sub-doubleword stores use read-modify-write.
module load_store_unit #(
    parameter int MEM_BYTES    = 128,
    parameter bit STRICT_ALIGN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [63:0] mem_address,
    output logic [63:0] mem_writeData,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [63:0] mem_read_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [64:0] LAST = 65'(MEM_BYTES - 1);

    state_t      state, state_nx;
    logic        r_write;
    logic [2:0]  r_f3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] rdbuf;
    logic [63:0] wd_q;
    logic        r_fault;

    logic        req_fire;
    logic        req_flt;
    logic [64:0] end_addr;
    logic [63:0] amask;
    logic [63:0] merged;
    logic [63:0] ext;

    assign req_fire = req_valid && req_ready;

    // 65-bit end address so addresses near 2^64 fault rather than wrap
    always_comb begin
        end_addr = {1'b0, req_addr} + 65'd7;
        amask    = 64'd0;
        unique case (req_funct3[1:0])
            2'd0: amask = 64'd0;
            2'd1: amask = 64'd1;
            2'd2: amask = 64'd3;
            2'd3: amask = 64'd7;
        endcase
        req_flt = (end_addr > LAST)
               || (req_write && req_funct3[2])
               || (req_funct3 == 3'b111)
               || (STRICT_ALIGN && ((req_addr & amask) != 64'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_fire) begin
                    if (req_flt) begin
                        state_nx = RESP;
                    end else if (req_write && req_funct3 == 3'b011) begin
                        state_nx = WRITE;
                    end else begin
                        state_nx = READ;
                    end
                end
            end
            READ:  state_nx = r_write ? WRITE : RESP;
            WRITE: state_nx = RESP;
            RESP:  state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_fault <= 1'b0;
            rdbuf   <= 64'd0;
            wd_q    <= 64'd0;
        end else begin
            if (req_fire) begin
                r_write <= req_write;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_fault <= req_flt;
            end
            if (state == READ) begin
                rdbuf <= mem_read_data;
            end
            if (state == WRITE) begin
                wd_q <= merged;
            end
        end
    end

    // store data: low 1/2/4 bytes of wdata over the old doubleword
    always_comb begin
        merged = r_wdata;
        unique case (r_f3[1:0])
            2'd0: merged = {rdbuf[63:8], r_wdata[7:0]};
            2'd1: merged = {rdbuf[63:16], r_wdata[15:0]};
            2'd2: merged = {rdbuf[63:32], r_wdata[31:0]};
            2'd3: merged = r_wdata;
        endcase
    end

    always_comb begin
        ext = 64'd0;
        unique case (r_f3)
            3'b000: ext = {{56{rdbuf[7]}}, rdbuf[7:0]};
            3'b001: ext = {{48{rdbuf[15]}}, rdbuf[15:0]};
            3'b010: ext = {{32{rdbuf[31]}}, rdbuf[31:0]};
            3'b011: ext = rdbuf;
            3'b100: ext = {56'd0, rdbuf[7:0]};
            3'b101: ext = {48'd0, rdbuf[15:0]};
            3'b110: ext = {32'd0, rdbuf[31:0]};
            default: ext = 64'd0;
        endcase
    end

    always_comb begin
        req_ready     = rst_n && (state == IDLE);
        resp_valid    = 1'b0;
        resp_rdata    = 64'd0;
        resp_fault    = 1'b0;
        mem_address   = r_addr;
        mem_writeData = wd_q;
        mem_MemWrite  = 1'b0;
        mem_MemRead   = 1'b0;
        busy          = (state != IDLE);
        unique case (state)
            READ: mem_MemRead = 1'b1;
            WRITE: begin
                mem_MemWrite  = 1'b1;
                mem_writeData = merged;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = r_fault;
                resp_rdata = (r_fault || r_write) ? 64'd0 : ext;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a byte
// memory model, directed plan cases and randomized traffic.
module tb_load_store_unit;

    localparam int MB = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_address;
    logic [63:0] mem_writeData;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [63:0] mem_read_data;
    logic        busy;

    logic        sa_req_valid = 1'b0;
    logic        sa_req_ready;
    logic [63:0] sa_req_addr = 64'd0;
    logic        sa_resp_valid;
    logic [63:0] sa_resp_rdata;
    logic        sa_resp_fault;
    logic [63:0] sa_mem_address;
    logic [63:0] sa_mem_writeData;
    logic        sa_mem_MemWrite;
    logic        sa_mem_MemRead;
    logic        sa_busy;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MB), .STRICT_ALIGN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    load_store_unit #(.MEM_BYTES(MB), .STRICT_ALIGN(1'b1)) u_sa (
        .clk(clk), .rst_n(rst_n),
        .req_valid(sa_req_valid), .req_ready(sa_req_ready),
        .req_write(1'b0), .req_funct3(3'b010),
        .req_addr(sa_req_addr), .req_wdata(64'd0),
        .resp_valid(sa_resp_valid), .resp_ready(1'b1),
        .resp_rdata(sa_resp_rdata), .resp_fault(sa_resp_fault),
        .mem_address(sa_mem_address), .mem_writeData(sa_mem_writeData),
        .mem_MemWrite(sa_mem_MemWrite), .mem_MemRead(sa_mem_MemRead),
        .mem_read_data(64'd0), .busy(sa_busy)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
        int          lat;
        int          nrd;
        int          nwr;
        int          hs;
        bit          has_k;
        logic [63:0] kval;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] mem [MB];
    logic [7:0] ref_mem [MB];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rr_mode = 1;

    // memory attached to the DUT: combinational read, commit on edge
    always_comb begin
        mem_read_data = 64'd0;
        if (mem_address <= 64'(MB - 8)) begin
            for (int i = 0; i < 8; i++) begin
                mem_read_data[8*i +: 8] = mem[int'(mem_address[6:0]) + i];
            end
        end
    end

    initial begin
        for (int i = 0; i < MB; i++) mem[i] = 8'(i + 1);
        forever begin
            @(posedge clk);
            if (mem_MemWrite && mem_address <= 64'(MB - 8)) begin
                for (int i = 0; i < 8; i++) begin
                    mem[int'(mem_address[6:0]) + i] <= mem_writeData[8*i +: 8];
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0: resp_ready = 1'b0;
            1: resp_ready = 1'b1;
            default: resp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: byte array semantics straight from the ISA rules
    function automatic exp_t model(input logic w, input logic [2:0] f3,
                                   input logic [63:0] a,
                                   input logic [63:0] wd);
        exp_t        e;
        int          sz;
        int          base;
        logic [63:0] v;
        sz = 1 << f3[1:0];
        e.fault = (a > 64'(MB - 8)) || (w && f3[2]) || (f3 == 3'b111);
        e.rdata = 64'd0;
        e.lat = 1;
        e.nrd = 0;
        e.nwr = 0;
        e.hs = 0;
        e.has_k = 1'b0;
        e.kval = 64'd0;
        if (!e.fault) begin
            base = int'(a[7:0]);
            if (w) begin
                for (int i = 0; i < sz; i++) ref_mem[base + i] = wd[8*i +: 8];
                e.nwr = 1;
                e.nrd = (sz == 8) ? 0 : 1;
                e.lat = e.nrd + 2;
            end else begin
                v = 64'd0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[base + i];
                if (!f3[2] && sz < 8 && v[8*sz-1]) begin
                    for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
                end
                e.rdata = v;
                e.nrd = 1;
                e.lat = 2;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic w, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd,
                         input bit has_k, input logic [63:0] kv);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = w;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: req_ready=%0b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        e = model(w, f3, a, wd);
        e.hs = cyc;
        e.has_k = has_k;
        e.kval = kv;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0 || busy) begin
            errors++;
            $display("FAIL drain: pending=%0d busy=%0b required 0 0",
                     sbq.size(), busy);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // monitor: pops one expectation per accepted response
    initial begin
        bit          seen;
        int          first;
        int          rd_cnt;
        int          wr_cnt;
        int          both_cnt;
        logic [63:0] hr;
        logic        hf;
        exp_t        e;
        seen = 0;
        first = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        both_cnt = 0;
        hr = 64'd0;
        hf = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
                rd_cnt = 0;
                wr_cnt = 0;
                both_cnt = 0;
            end else begin
                rd_cnt += int'(mem_MemRead);
                wr_cnt += int'(mem_MemWrite);
                both_cnt += int'(mem_MemRead && mem_MemWrite);
                if (resp_valid) begin
                    if (!seen) begin
                        seen = 1;
                        first = cyc;
                        hr = resp_rdata;
                        hf = resp_fault;
                    end else begin
                        chk("hold_rdata", resp_rdata, hr);
                        chk("hold_fault", 64'(resp_fault), 64'(hf));
                    end
                    chk("req_ready_in_resp", 64'(req_ready), 64'd0);
                    if (resp_ready) begin
                        if (sbq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_resp: got %h", resp_rdata);
                        end else begin
                            e = sbq.pop_front();
                            chk("rdata", resp_rdata, e.rdata);
                            chk("fault", 64'(resp_fault), 64'(e.fault));
                            chk("latency", 64'(first - e.hs), 64'(e.lat));
                            chk("memread_cycles", 64'(rd_cnt), 64'(e.nrd));
                            chk("memwrite_cycles", 64'(wr_cnt), 64'(e.nwr));
                            chk("rd_wr_overlap", 64'(both_cnt), 64'd0);
                            if (e.has_k) chk("known_value", resp_rdata, e.kval);
                        end
                        seen = 0;
                        rd_cnt = 0;
                        wr_cnt = 0;
                        both_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic sa_check(input logic [63:0] a, input logic ef,
                            input int elat);
        int n;
        int hs;
        int rds;
        n = 0;
        rds = 0;
        @(posedge clk);
        #1;
        sa_req_valid = 1'b1;
        sa_req_addr = a;
        @(negedge clk);
        while (!sa_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        hs = cyc;
        @(posedge clk);
        #1;
        sa_req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!sa_resp_valid && n < 20) begin
            rds += int'(sa_mem_MemRead || sa_mem_MemWrite);
            @(negedge clk);
            n++;
        end
        chk("sa_resp_valid", 64'(sa_resp_valid), 64'd1);
        chk("sa_fault", 64'(sa_resp_fault), 64'(ef));
        chk("sa_rdata", sa_resp_rdata, 64'd0);
        chk("sa_latency", 64'(cyc - hs), 64'(elat));
        chk("sa_mem_cycles", 64'(rds), ef ? 64'd0 : 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] wd;
        int          n;
        int          pick;
        for (int i = 0; i < MB; i++) ref_mem[i] = 8'(i + 1);
        #1;
        rst_n = 1'b0;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_memread", 64'(mem_MemRead), 64'd0);
        chk("rst_memwrite", 64'(mem_MemWrite), 64'd0);
        chk("rst_address", mem_address, 64'd0);
        chk("rst_wdata", mem_writeData, 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("req_ready_after_rst", 64'(req_ready), 64'd1);

        issue(0, 3'b011, 64'd0, 64'd0, 1, 64'h0807060504030201);
        issue(1, 3'b000, 64'd8, 64'hFF, 1, 64'd0);
        issue(0, 3'b000, 64'd8, 64'd0, 1, 64'hFFFFFFFFFFFFFFFF);
        issue(0, 3'b100, 64'd8, 64'd0, 1, 64'h00000000000000FF);
        issue(0, 3'b011, 64'd8, 64'd0, 1, 64'h100F0E0D0C0B0AFF);
        issue(1, 3'b001, 64'h20, 64'h1234ABCD, 1, 64'd0);
        issue(0, 3'b011, 64'h20, 64'd0, 1, 64'h282726252423ABCD);
        issue(1, 3'b011, 64'h40, 64'hDEADBEEF00C0FFEE, 1, 64'd0);
        issue(0, 3'b011, 64'h40, 64'd0, 1, 64'hDEADBEEF00C0FFEE);
        issue(0, 3'b000, 64'd121, 64'd0, 1, 64'd0);
        issue(0, 3'b000, 64'd120, 64'd0, 1, 64'h0000000000000079);
        issue(1, 3'b100, 64'd0, 64'h77, 1, 64'd0);
        issue(0, 3'b111, 64'd0, 64'd0, 1, 64'd0);
        issue(0, 3'b011, 64'hFFFFFFFFFFFFFFFC, 64'd0, 1, 64'd0);
        wait_idle();

        // back-pressure: response held while resp_ready stays low
        @(negedge clk);
        rr_mode = 0;
        issue(0, 3'b011, 64'd0, 64'd0, 1, 64'h0807060504030201);
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_resp_valid", 64'(resp_valid), 64'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_funct3 = 3'b011;
        req_addr = 64'd0;
        repeat (3) @(negedge clk);
        chk("bp_still_valid", 64'(resp_valid), 64'd1);
        chk("bp_still_busy", 64'(busy), 64'd1);
        req_valid = 1'b0;
        rr_mode = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("bp_idle_ready", 64'(req_ready), 64'd1);
        chk("bp_idle_valid", 64'(resp_valid), 64'd0);
        wait_idle();

        // reset while the SB write cycle is on the pins
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_funct3 = 3'b000;
        req_addr = 64'd16;
        req_wdata = 64'h55;
        @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mem_MemWrite && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mid_write_seen", 64'(mem_MemWrite), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_memwrite", 64'(mem_MemWrite), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_address", mem_address, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 3'b011, 64'd16, 64'd0, 1, 64'h1817161514131211);
        wait_idle();

        // randomized traffic with random response back-pressure
        @(negedge clk);
        rr_mode = 2;
        for (int t = 0; t < 250; t++) begin
            pick = $urandom_range(0, 19);
            if (pick == 0) a = {$urandom, $urandom};
            else if (pick == 1) a = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
            else a = 64'($urandom_range(0, MB - 1));
            wd = {$urandom, $urandom};
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, wd, 0,
                  64'd0);
        end
        wait_idle();
        @(negedge clk);
        rr_mode = 1;

        sa_check(64'd2, 1'b1, 1);
        sa_check(64'd4, 1'b0, 2);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
